// File: rtl/eth_tx_frame_arbiter_if.sv
// AXI-Stream bundle for the TX arbiter; N lanes of 8-bit data with per-lane sideband.
interface eth_tx_frame_arbiter_if #(
    parameter int N = 1
);
    logic [N*8-1:0] tdata;
    logic [N-1:0]   tkeep;
    logic [N-1:0]   tvalid;
    logic [N-1:0]   tready;
    logic [N-1:0]   tlast;
    logic [N-1:0]   tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one 8-bit MAC TX stream between PORTS sources,
// with forced truncation (tlast+tuser) of frames longer than MAX_FRAME_LEN beats.
module eth_tx_arb_lane (
    input  logic i_grant,
    input  logic i_pass,
    input  logic i_drain,
    input  logic i_m_tready,
    output logic o_s_tready
);
    // Draining swallows beats regardless of the MAC.
    assign o_s_tready = i_grant & ((i_pass & i_m_tready) | i_drain);
endmodule

module eth_tx_frame_arbiter #(
    parameter int PORTS         = 2,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_W         = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    eth_tx_frame_arbiter_if.slave  s_axis,
    eth_tx_frame_arbiter_if.master m_axis,
    output logic [PORTS-1:0]      o_grant,
    output logic                  o_truncated
);
    localparam int PTR_W = $clog2(PORTS);

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DRAIN} state_t;

    state_t            r_state, w_state_nxt;
    logic [PORTS-1:0]  r_grant, w_grant_nxt;
    logic [PTR_W-1:0]  r_last_ptr, w_last_ptr_nxt;
    logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic              r_truncated, w_truncated_nxt;

    logic              w_pass, w_drain, w_found;
    logic [PTR_W:0]    w_idx;
    logic [PTR_W-1:0]  w_pick;
    logic [7:0]        w_sel_data;
    logic              w_sel_valid, w_sel_last, w_sel_user, w_sel_keep;
    logic              w_trunc_beat, w_m_hs, w_drain_hs;
    logic [PORTS-1:0]  w_s_tready;

    assign w_pass  = (r_state == S_PASS);
    assign w_drain = (r_state == S_DRAIN);

    // Rotating search starting just after the last owner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= PORTS; k++) begin
            w_idx = {1'b0, r_last_ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(PORTS))
                w_idx = w_idx - (PTR_W+1)'(PORTS);
            if (!w_found && s_axis.tvalid[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PTR_W-1:0];
            end
        end
    end

    // last_ptr always equals the index of the current owner.
    assign w_sel_data  = s_axis.tdata[{r_last_ptr, 3'b000} +: 8];
    assign w_sel_valid = s_axis.tvalid[r_last_ptr];
    assign w_sel_last  = s_axis.tlast[r_last_ptr];
    assign w_sel_user  = s_axis.tuser[r_last_ptr];
    assign w_sel_keep  = s_axis.tkeep[r_last_ptr];

    assign w_trunc_beat = w_pass & (r_beat_cnt == CNT_W'(MAX_FRAME_LEN-1)) & ~w_sel_last;
    assign w_m_hs       = w_pass & w_sel_valid & m_axis.tready[0];
    assign w_drain_hs   = w_drain & w_sel_valid;

    assign m_axis.tdata  = w_pass ? w_sel_data : 8'h00;
    assign m_axis.tvalid = w_pass & w_sel_valid;
    assign m_axis.tkeep  = w_pass & w_sel_keep;
    assign m_axis.tlast  = w_pass & (w_sel_last | w_trunc_beat);
    assign m_axis.tuser  = w_pass & (w_sel_user | w_trunc_beat);

    for (genvar i = 0; i < PORTS; i++) begin : g_lane
        eth_tx_arb_lane u_lane (
            .i_grant    (r_grant[i]),
            .i_pass     (w_pass),
            .i_drain    (w_drain),
            .i_m_tready (m_axis.tready[0]),
            .o_s_tready (w_s_tready[i])
        );
    end
    assign s_axis.tready = w_s_tready;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_last_ptr_nxt  = r_last_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_truncated_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_PASS;
                    w_grant_nxt    = PORTS'(1) << w_pick;
                    w_last_ptr_nxt = w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_PASS: begin
                if (w_m_hs) begin
                    if (w_sel_last) begin
                        w_state_nxt    = S_IDLE;
                        w_grant_nxt    = '0;
                        w_beat_cnt_nxt = '0;
                    end else if (w_trunc_beat) begin
                        w_state_nxt     = S_DRAIN;
                        w_beat_cnt_nxt  = '0;
                        w_truncated_nxt = 1'b1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drain_hs && w_sel_last) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_last_ptr  <= PTR_W'(PORTS-1);
            r_beat_cnt  <= '0;
            r_truncated <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_last_ptr  <= w_last_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_truncated <= w_truncated_nxt;
        end
    end

    assign o_grant     = r_grant;
    assign o_truncated = r_truncated;
endmodule
